// File: rtl/data_ram_master_pkg.sv
// rtl/data_ram_master_pkg.sv - shared bus widths and data region bounds for the data RAM master
package data_ram_master_pkg;

  // Byte address width of the data RAM bus.
  localparam int ADDRESS_BUS_WIDTH = 8;

  // One word is three bytes, stored little-endian in the RAM.
  localparam int DATA_BUS_WIDTH = 24;

  // Total byte address space; the lower half is the data region.
  localparam int NUM_ADDRESS = 256;

  localparam int DATA_REGION_BYTES = NUM_ADDRESS / 2;

  // Highest byte address whose full 3-byte word still fits inside the data region.
  localparam logic [ADDRESS_BUS_WIDTH-1:0] LAST_WORD_ADDR =
    ADDRESS_BUS_WIDTH'(DATA_REGION_BYTES - 3);

endpackage

// File: rtl/data_ram_master.sv
// rtl/data_ram_master.sv - data RAM bus initiator (optional DATA_RAM_BOUNDS_CHECK_EN range check)
module data_ram_master
  import data_ram_master_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_rnw,
  input  logic [ADDRESS_BUS_WIDTH-1:0] req_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DATA_BUS_WIDTH-1:0]    resp_rdata,
  output logic                         resp_err,
  output logic                         mem_cs,
  output logic                         mem_read_not_write,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
  output logic [DATA_BUS_WIDTH-1:0]    mem_write_data,
  input  logic [DATA_BUS_WIDTH-1:0]    mem_read_data
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       req_fire;
  logic       resp_fire;
  logic       addr_ok;

  // req_ready is only high in IDLE and resp_valid only in DONE, so these
  // already imply the right state.
  assign req_fire  = req_valid && req_ready;
  assign resp_fire = resp_valid && resp_ready;

`ifdef DATA_RAM_BOUNDS_CHECK_EN
  // A word starting past the last fitting byte would spill out of the data region.
  assign addr_ok = (req_addr <= LAST_WORD_ADDR);
`else
  assign addr_ok  = 1'b1;
  assign resp_err = 1'b0;
`endif

  // Next-state decode: one request in flight, load takes the extra CAPTURE step.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_fire) begin
          next_state = addr_ok ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        // mem_read_not_write still holds the latched direction during ISSUE.
        next_state = mem_read_not_write ? CAPTURE : DONE;
      end
      CAPTURE: begin
        next_state = DONE;
      end
      DONE: begin
        if (resp_fire) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // req_ready registered from the state we are about to enter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
    end else begin
      req_ready <= (next_state == IDLE);
    end
  end

  // RAM bus: latch the request on accept, pulse cs for the ISSUE cycle only,
  // then park the direction back at read while address/data hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cs             <= 1'b0;
      mem_read_not_write <= 1'b1;
      mem_address        <= '0;
      mem_write_data     <= '0;
    end else if ((state == IDLE) && req_fire && addr_ok) begin
      mem_cs             <= 1'b1;
      mem_read_not_write <= req_rnw;
      mem_address        <= req_addr;
      mem_write_data     <= req_wdata;
    end else if (state == ISSUE) begin
      mem_cs             <= 1'b0;
      mem_read_not_write <= 1'b1;
    end
  end

  // Read data is sampled only at the end of CAPTURE, when the RAM is driving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= '0;
    end else if (state == CAPTURE) begin
      resp_rdata <= mem_read_data;
    end
  end

  // resp_valid rises one cycle into DONE and drops on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= (state == DONE) && !resp_fire;
    end
  end

`ifdef DATA_RAM_BOUNDS_CHECK_EN
  // Out-of-range flag: set on a refused accept, cleared when the response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_err <= 1'b0;
    end else if ((state == IDLE) && req_fire && !addr_ok) begin
      resp_err <= 1'b1;
    end else if (resp_fire) begin
      resp_err <= 1'b0;
    end
  end
`endif

endmodule
